// File: rtl/uart_pkg.sv
// Shared UART-side definitions: arbiter state encoding, byte width and the
// clock/baud figures that size the transmit watchdog.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    localparam int UART_DATA_W = 8;
    localparam int CLK_HZ      = 100_000_000;
    localparam int BAUD        = 115_200;

    // One start + 8 data + 1 stop bit.
    localparam int FRAME_CYCLES = 10 * (CLK_HZ / BAUD);

    // About two dozen frames of slack, rounded down to a whole 10k clocks.
    localparam int TIMEOUT_CYCLES_DFLT = ((24 * FRAME_CYCLES) / 10_000) * 10_000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last winner
// and wraps, so the most recently served requester has the lowest priority.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any_grant
);

    localparam int IW = $clog2(N);

    // rot[k] is the request that sits k+1 places after the last winner.
    logic [N-1:0]  rot;
    logic [IW-1:0] pick;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [IW-1:0] src;
            assign src     = IW'((32'(last) + 32'(gi) + 32'd1) % N);
            assign rot[gi] = req[src];
        end
    endgenerate

    always_comb begin
        pick      = '0;
        grant     = '0;
        any_grant = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick = IW'(i);
            end
        end
        grant_idx = IW'((32'(last) + 32'(pick) + 32'd1) % N);
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources: round-robin grant,
// one-cycle start pulse, wait for tx_done, inter-frame gap and a watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_DATA_W,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_en,
    input  logic                        tx_done,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err,
    input  logic                        err_clr
);

    localparam int IW       = $clog2(NUM_REQ);
    localparam int CNT_MAX  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam arb_state_e AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_e          state_reg, state_next;
    logic [NUM_REQ-1:0]  ack_reg, ack_next;
    logic                tx_en_reg, tx_en_next;
    logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
    logic [IW-1:0]       grant_id_reg, grant_id_next;
    logic [IW-1:0]       last_reg, last_next;
    logic                busy_reg, busy_next;
    logic                err_reg, err_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [CW-1:0]       cnt_inc;
    logic                tx_done_q;
    logic                done_evt;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic [DATA_W-1:0]   req_bytes [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .last      (last_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // A level-held tx_done only ever produces a single completion.
    assign done_evt = tx_done & ~tx_done_q;
    assign cnt_inc  = cnt_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        ack_next      = '0;
        tx_en_next    = 1'b0;
        tx_data_next  = tx_data_reg;
        grant_id_next = grant_id_reg;
        last_next     = last_reg;
        err_next      = err_reg;
        cnt_next      = cnt_reg;
        if (err_clr) begin
            err_next = 1'b0;
        end
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    tx_data_next  = req_bytes[arb_idx];
                    grant_id_next = arb_idx;
                    last_next     = arb_idx;
                    ack_next      = arb_grant;
                    tx_en_next    = 1'b1;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                cnt_next   = '0;
                state_next = BUSY;
            end
            BUSY: begin
                if (done_evt) begin
                    cnt_next   = '0;
                    state_next = AFTER_FRAME;
                end else if (cnt_inc == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Stuck transmitter: the byte is dropped, never retried.
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = AFTER_FRAME;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            GAP: begin
                if (cnt_reg == CW'(GAP_LAST)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ack_reg      <= '0;
            tx_en_reg    <= 1'b0;
            tx_data_reg  <= '0;
            grant_id_reg <= '0;
            last_reg     <= IW'(NUM_REQ - 1);
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
            tx_done_q    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ack_reg      <= ack_next;
            tx_en_reg    <= tx_en_next;
            tx_data_reg  <= tx_data_next;
            grant_id_reg <= grant_id_next;
            last_reg     <= last_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
            cnt_reg      <= cnt_next;
            tx_done_q    <= tx_done;
        end
    end

    assign req_ack     = ack_reg;
    assign tx_en       = tx_en_reg;
    assign tx_data     = tx_data_reg;
    assign grant_id    = grant_id_reg;
    assign busy        = busy_reg;
    assign timeout_err = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with a transaction-level
// reference model and a simple uart_top stand-in driving tx_done.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int G     = 16;
    localparam int TO    = 50;
    localparam int FRAME = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ack;
    logic [DW-1:0]     tx_data;
    logic              tx_en;
    logic              tx_done = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;
    logic              err_clr = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .DATA_W         (DW),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    int        m_last      = N - 1;
    int        m_free_at   = 0;
    int        m_grant_cyc = -1;
    int        m_fire_at   = -1;
    int        m_gid       = 0;
    logic [7:0] m_data     = '0;
    bit        m_err       = 1'b0;

    // uart_top stand-in and requester behaviour
    bit        stub       = 1'b0;
    int        hold_len   = 1;
    int        done_q[$];
    int        done_until = -1;
    logic [7:0] rx_byte   = '0;
    bit        auto_drop  = 1'b1;
    int        grant_log[$];
    int        en_log[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        logic [N-1:0]    p_valid;
        logic [N*DW-1:0] p_data;
        bit              p_rst;
        bit              p_clr;
        logic [N-1:0]    exp_ack;
        p_valid = req_valid;
        p_data  = req_data;
        p_rst   = rst;
        p_clr   = err_clr;
        @(posedge clk);
        #1;
        cyc++;
        if (p_rst) begin
            m_last      = N - 1;
            m_free_at   = cyc;
            m_grant_cyc = -1;
            m_fire_at   = -1;
            m_gid       = 0;
            m_data      = '0;
            m_err       = 1'b0;
            done_q.delete();
            done_until  = -1;
        end else begin
            if (m_fire_at == cyc) m_err = 1'b1;
            else if (p_clr) m_err = 1'b0;
            if (cyc - 1 >= m_free_at && p_valid != '0) begin
                m_gid       = rr_pick(p_valid, m_last);
                m_last      = m_gid;
                m_data      = p_data[m_gid*DW +: DW];
                m_grant_cyc = cyc;
                if (stub) begin
                    m_fire_at = cyc + TO;
                    m_free_at = cyc + TO + G;
                end else begin
                    m_free_at = cyc + FRAME + G + 2;
                end
            end
        end
        exp_ack = (m_grant_cyc == cyc) ? N'(1 << m_gid) : '0;
        check("req_ack", 32'(req_ack), 32'(exp_ack));
        check("tx_en", 32'(tx_en), 32'(m_grant_cyc == cyc));
        check("tx_data", 32'(tx_data), 32'(m_data));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("busy", 32'(busy), 32'(!p_rst && cyc < m_free_at));
        check("timeout_err", 32'(timeout_err), 32'(m_err));

        for (int i = 0; i < N; i++) begin
            if (req_ack[i] === 1'b1) begin
                grant_log.push_back(i);
                $display("cyc %0d: grant req%0d byte %02h", cyc, i, tx_data);
            end
        end
        if (auto_drop) req_valid = req_valid & ~req_ack;
        if (tx_en === 1'b1) begin
            rx_byte = tx_data;
            en_log.push_back(cyc);
            if (!stub) done_q.push_back(cyc + FRAME + 1);
        end
        if (done_q.size() > 0 && done_q[0] == cyc) begin
            void'(done_q.pop_front());
            done_until = cyc + hold_len - 1;
        end
        tx_done = (cyc <= done_until);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_grants(int target, int budget, string tag);
        int k;
        k = 0;
        while (grant_log.size() < target && k < budget) begin
            step();
            k++;
        end
        check({tag, "_wait"}, 32'(grant_log.size() >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        err_clr   = 1'b0;
        stub      = 1'b0;
        hold_len  = 1;
        tx_done   = 1'b0;
        step();
        rst = 1'b0;
        grant_log.delete();
        en_log.delete();
    endtask

    initial begin
        int x;
        int t;
        int k;

        // Reset state is checked by the per-cycle model
        step();
        step();
        rst = 1'b0;

        // Single request from requester 2
        grant_log.delete();
        en_log.delete();
        req_data  = 32'h00A5_0000;
        req_valid = 4'b0100;
        x = cyc;
        run_grants(1, 10, "t1");
        check("t1_gid", 32'(grant_log[0]), 32'd2);
        check("t1_latency", 32'(en_log[0] - x), 32'd1);
        check("t1_rx", 32'(rx_byte), 32'hA5);
        run(FRAME + G + 4);

        // All four valid: strict rotation and frame spacing
        do_reset();
        req_data  = 32'h4433_2211;
        req_valid = 4'b1111;
        run_grants(4, 400, "t2");
        for (int i = 0; i < 4; i++) check("t2_order", 32'(grant_log[i]), 32'(i));
        for (int i = 0; i < 3; i++) check("t2_spacing", 32'(en_log[i+1] - en_log[i]), 32'(FRAME + G + 3));
        check("t2_rx", 32'(rx_byte), 32'h44);

        // Requester 1 re-asserts while 3 waits
        do_reset();
        req_data  = 32'h3300_1100;
        req_valid = 4'b0010;
        run_grants(1, 10, "t3a");
        req_valid = req_valid | 4'b1010;
        run_grants(3, 200, "t3b");
        check("t3_g0", 32'(grant_log[0]), 32'd1);
        check("t3_g1", 32'(grant_log[1]), 32'd3);
        check("t3_g2", 32'(grant_log[2]), 32'd1);

        // Watchdog with a silent transmitter
        do_reset();
        stub      = 1'b1;
        req_data  = 32'h0000_005A;
        req_valid = 4'b0001;
        run_grants(1, 10, "t4a");
        t = en_log[0];
        k = 0;
        while (timeout_err !== 1'b1 && k < 100) begin step(); k++; end
        check("t4_err_rise", 32'(cyc - t), 32'(TO));
        k = 0;
        while (busy !== 1'b0 && k < 100) begin step(); k++; end
        check("t4_idle_at", 32'(cyc - t), 32'(TO + G));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4_clr", 32'(timeout_err), 32'd0);
        req_valid = 4'b0001;
        run_grants(2, 10, "t4b");
        t = en_log[1];
        while (cyc < t + TO - 1) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4_set_wins", 32'(timeout_err), 32'd1);
        stub = 1'b0;
        run(G + 2);

        // tx_done held high for 20 cycles counts once
        do_reset();
        hold_len  = 20;
        req_data  = 32'h0077_6655;
        req_valid = 4'b0001;
        run_grants(1, 10, "t5a");
        req_valid = 4'b0010;
        run_grants(2, 100, "t5b");
        hold_len  = 1;
        req_valid = 4'b0100;
        run_grants(3, 100, "t5c");
        check("t5_spacing1", 32'(en_log[1] - en_log[0]), 32'(FRAME + G + 3));
        check("t5_spacing2", 32'(en_log[2] - en_log[1]), 32'(FRAME + G + 3));

        // Reset during BUSY
        do_reset();
        req_data  = 32'h0000_C300;
        req_valid = 4'b0100;
        run_grants(1, 10, "t6a");
        run(5);
        rst = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_tx_en", 32'(tx_en), 32'd0);
        check("t6_gid", 32'(grant_id), 32'd0);
        req_data  = 32'hE100_0000;
        req_valid = 4'b1000;
        en_log.delete();
        grant_log.delete();
        step();
        rst = 1'b0;
        x = cyc;
        run_grants(1, 10, "t6b");
        check("t6_latency", 32'(en_log[0] - x), 32'd1);
        check("t6_gid3", 32'(grant_log[0]), 32'd3);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            req_data = {$urandom(), $urandom()} >> 16;
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] && $urandom_range(0, 19) == 0) req_valid[r] = 1'b1;
                else if (req_valid[r] && $urandom_range(0, 199) == 0) req_valid[r] = 1'b0;
            end
            err_clr  = ($urandom_range(0, 39) == 0);
            stub     = ($urandom_range(0, 7) == 0);
            hold_len = $urandom_range(1, 3);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single transmitter of uart_top among NUM_REQ byte sources.
- Accepts one byte per grant and drives uart_top's data_in_tx/tx_en.
- Waits for completion on tx_done, enforces an inter-frame gap, and flags a transmitter that never completes (watchdog).
- Sits between the on-chip requesters (status reporter, echo path, debug port) and uart_top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width matching uart_top data_in_tx.
- GAP_CYCLES, 16, idle clocks between frames; 0 means no gap.
- TIMEOUT_CYCLES, 200000, max clocks in BUSY before the watchdog fires (must exceed one 10-bit frame at the configured baud).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte-pending flag, held until acked.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_data  out  DATA_W  to uart_top data_in_tx.
- tx_en  out  1  to uart_top tx_en; one-cycle start pulse.
- tx_done  in  1  from uart_top tx_done.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky watchdog flag.
- err_clr  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; req_ack=0, tx_en=0, tx_data=0, grant_id=0, busy=0, timeout_err=0.
  - last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
  - Counters=0, tx_done_q=0.
- All outputs are registered.
- done_evt = tx_done & ~tx_done_q (rising edge). A level-held tx_done never counts twice.
- States: IDLE, LOAD, BUSY, GAP.
- IDLE:
  - At each edge, search req_valid starting at last+1, wrapping modulo NUM_REQ. The first set bit wins.
  - On a win: capture the winner's byte into tx_data, set grant_id and last to the winner, pulse req_ack[winner] for the next cycle, go to LOAD.
  - No valid requests: stay in IDLE and hold all outputs.
- LOAD: exactly one cycle with tx_en=1 (aligned with req_ack). Then go to BUSY with the timeout counter cleared.
- BUSY:
  - tx_en=0; the counter increments every cycle.
  - done_evt: go to GAP, or to IDLE if GAP_CYCLES=0.
  - Counter reaches TIMEOUT_CYCLES-1 with no done_evt: set timeout_err=1, go to GAP (or IDLE). The byte is dropped, not retried.
  - done_evt and timeout on the same cycle: done wins, timeout_err is unchanged.
- GAP: count GAP_CYCLES clocks, then IDLE. Requests are not evaluated during GAP.
- Latency: with the arbiter IDLE, req_valid sampled at edge k gives req_ack and tx_en high during cycle k+1.
- Back-to-back frame spacing (start to start) is frame time + GAP_CYCLES + 3 clocks.
- Fairness:
  - The requester just served gets lowest priority next round.
  - With all NUM_REQ valid, grants go 0,1,2,3,0,...
- A requester dropping req_valid before its ack is simply skipped; no error is raised.
- req_data is sampled only on the grant edge. Later changes do not affect the frame in flight.
- err_clr clears timeout_err. If err_clr and a new timeout hit the same edge, the set wins.
- rst asserted mid-frame forces IDLE immediately. uart_top shares rst, so no partial frame is tracked.
- tx_done high while in IDLE, LOAD or GAP is ignored, but tx_done_q still tracks it.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, LOAD, BUSY, GAP}.
  - UART_DATA_W=8.
  - CLK_HZ and BAUD constants, from which TIMEOUT_CYCLES is derived.
- One natural sub-module: rr_arbiter.
  - Combinational round-robin priority pick: inputs req and last; outputs grant one-hot, grant_idx and any_grant.
  - Reused later for the RX dispatch path.

Test Plan:
- After reset, only req_valid=4'b0100 with byte 8'hA5 → req_ack=4'b0100 and tx_en one cycle later with tx_data=8'hA5, grant_id=2; the bench's uart_top loopback gives rx data 8'hA5.
- All four valid (bytes 8'h11, 8'h22, 8'h33, 8'h44) and held → four frames in order 0,1,2,3; each ack a single-cycle pulse; start-to-start spacing equals frame + GAP_CYCLES + 3.
- Requester 1 re-asserts immediately after its grant while 3 is pending → order 1,3,1; requester 1 never gets two consecutive grants while 3 waits.
- tx_done tied low (stubbed uart) with TIMEOUT_CYCLES=50 → timeout_err rises 50 cycles after tx_en and busy returns low after the gap; err_clr pulse → timeout_err=0.
- tx_done held high for 20 cycles → exactly one completion is counted and the next grant is not issued early.
- rst pulsed during BUSY → next cycle busy=0, tx_en=0, grant_id=0; after release, a pending req 3 is granted with normal latency.
